// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoder select path.
// The registered grant index drives the decoder inputs (a = gnt_idx[1], b = gnt_idx[0]).
// Each grant is held for at most MAX_HOLD cycles. At least GAP_CYCLES grant-free cycles
// separate any two grants. A grant that is cut off by the hold limit raises preempt
// for one cycle.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    gnt_idx_q;
  logic          gnt_valid_q;
  logic          preempt_q;
  logic [HW-1:0] hold_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [1:0]    last_q;

  // Winner search: {found, index}. The scan starts one past the last winner and wraps.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!res[2] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [2:0] arb_d;
  logic [3:0] win_oh_d;

  assign arb_d    = rr_pick(req, last_q);
  assign win_oh_d = 4'b0001 << arb_d[1:0];

  // Arbitration FSM. The grant, index, valid and preempt outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 2'd3;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_d[2]) begin
            gnt_q       <= win_oh_d;
            gnt_idx_q   <= arb_d[1:0];
            gnt_valid_q <= 1'b1;
            last_q      <= arb_d[1:0];
            hold_cnt_q  <= HOLD_ONE;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!req[gnt_idx_q]) begin
            // Normal release. This takes priority over the hold limit in the same cycle.
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            gap_cnt_q   <= '0;
            state_q     <= S_GAP;
          end else if (hold_cnt_q == HOLD_MAX) begin
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b1;
            gap_cnt_q   <= '0;
            state_q     <= S_GAP;
          end else begin
            hold_cnt_q  <= hold_cnt_q + HOLD_ONE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            if (arb_d[2]) begin
              gnt_q       <= win_oh_d;
              gnt_idx_q   <= arb_d[1:0];
              gnt_valid_q <= 1'b1;
              last_q      <= arb_d[1:0];
              hold_cnt_q  <= HOLD_ONE;
              state_q     <= S_GRANT;
            end else begin
              state_q     <= S_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter (MAX_HOLD=8, GAP_CYCLES=1).
// The stimulus process pushes hand-computed per-cycle expectations.
// The monitor pops them on the falling edge and compares.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      nm;
  } exp_t;

  exp_t sb[$];

  rr_decoder_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got gnt=%b idx=%0d vld=%b pre=%b, want gnt=%b idx=%0d vld=%b pre=%b",
               nm, cyc, act[7:4], act[3:2], act[1], act[0],
               expv[7:4], expv[3:2], expv[1], expv[0]);
    end
  endtask

  task automatic expect_at(input int off, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic p, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.val = {g, i, v, p};
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expect_at(0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_assert");
    tick();
    rst = 1'b0;
    expect_at(0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_release");
    tick();
  endtask

  // Monitor: check the grant invariants every cycle, then retire the due expectations.
  always @(negedge clk) begin
    n_chk++;
    if (gnt_valid !== (|gnt)) begin
      n_fail++;
      $display("FAIL inv_valid @cyc %0d: got vld=%b, want %b (gnt=%b)", cyc, gnt_valid, |gnt, gnt);
    end
    n_chk++;
    if ((gnt & (gnt - 4'd1)) !== 4'd0) begin
      n_fail++;
      $display("FAIL inv_onehot @cyc %0d: got gnt=%b, want at most one bit set", cyc, gnt);
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        check(sb[i].nm, {gnt, gnt_idx, gnt_valid, preempt}, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cyc %0d, want end of stimulus", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] m;
    rst = 1'b0;
    req = 4'b0000;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    expect_at(0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_hold");
    tick();
    rst = 1'b0;

    // Quiet after reset: no request for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      expect_at(1, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_no_req");
      tick();
    end

    // Single requester 2 for three cycles.
    req = 4'b0100;
    expect_at(1, 4'b0100, 2'd2, 1'b1, 1'b0, "single_g1");
    expect_at(2, 4'b0100, 2'd2, 1'b1, 1'b0, "single_g2");
    expect_at(3, 4'b0100, 2'd2, 1'b1, 1'b0, "single_g3");
    expect_at(4, 4'b0000, 2'd2, 1'b0, 1'b0, "single_gap");
    expect_at(5, 4'b0000, 2'd2, 1'b0, 1'b0, "single_idle");
    tick(); tick(); tick();
    req = 4'b0000;
    tick(); tick(); tick();

    // All requesting: grants rotate 0,1,2,3,0 for 8 cycles each, then one preempt gap cycle.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      m = 2'(g);
      for (int k = 0; k < 8; k++)
        expect_at(1 + 9 * g + k, 4'b0001 << m, m, 1'b1, 1'b0, "rot_grant");
      expect_at(9 + 9 * g, 4'b0000, m, 1'b0, 1'b1, "rot_preempt");
    end
    for (int k = 0; k < 45; k++) tick();
    req = 4'b0000;
    expect_at(1, 4'b0000, 2'd0, 1'b0, 1'b0, "rot_idle");
    tick(); tick();

    // Wrap-around: 0 first, then 3, then 0 again.
    do_reset();
    req = 4'b1001;
    expect_at(1, 4'b0001, 2'd0, 1'b1, 1'b0, "wrap_m0_a");
    expect_at(2, 4'b0001, 2'd0, 1'b1, 1'b0, "wrap_m0_b");
    expect_at(3, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_gap1");
    expect_at(4, 4'b1000, 2'd3, 1'b1, 1'b0, "wrap_m3");
    expect_at(5, 4'b0000, 2'd3, 1'b0, 1'b0, "wrap_gap2");
    expect_at(6, 4'b0001, 2'd0, 1'b1, 1'b0, "wrap_m0_again");
    expect_at(7, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_gap3");
    tick(); tick();
    req = 4'b1000;
    tick(); tick();
    req = 4'b0001;
    tick(); tick();
    req = 4'b0000;
    tick(); tick();

    // Master 1 drops its request in the 8th granted cycle: normal release, no preempt.
    req = 4'b0010;
    for (int k = 1; k <= 8; k++)
      expect_at(k, 4'b0010, 2'd1, 1'b1, 1'b0, "drop8_grant");
    expect_at(9, 4'b0000, 2'd1, 1'b0, 1'b0, "drop8_release");
    expect_at(10, 4'b0000, 2'd1, 1'b0, 1'b0, "drop8_idle");
    for (int k = 0; k < 8; k++) tick();
    req = 4'b0000;
    tick(); tick();

    // Lone requester is preempted and then regranted after the gap.
    req = 4'b0100;
    for (int k = 1; k <= 8; k++)
      expect_at(k, 4'b0100, 2'd2, 1'b1, 1'b0, "lone_grant");
    expect_at(9, 4'b0000, 2'd2, 1'b0, 1'b1, "lone_preempt");
    expect_at(10, 4'b0100, 2'd2, 1'b1, 1'b0, "lone_regrant");
    expect_at(11, 4'b0000, 2'd2, 1'b0, 1'b0, "lone_release");
    for (int k = 0; k < 10; k++) tick();
    req = 4'b0000;
    tick(); tick();

    // Asynchronous reset between edges while master 0 holds the grant.
    req = 4'b0001;
    expect_at(1, 4'b0001, 2'd0, 1'b1, 1'b0, "pre_rst_grant");
    tick();
    #6;
    rst = 1'b1;
    #1;
    check("async_rst_clear", {gnt, gnt_idx, gnt_valid, preempt}, 8'h00);
    req = 4'b1010;
    expect_at(1, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_held");
    tick();
    rst = 1'b0;
    expect_at(1, 4'b0010, 2'd1, 1'b1, 1'b0, "post_rst_m1");
    tick();
    req = 4'b0000;
    expect_at(1, 4'b0000, 2'd1, 1'b0, 1'b0, "post_rst_release");
    tick(); tick(); tick();

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
